// File: rtl/alu_defs_pkg.sv
// Shared ALU op codes and sequencer FSM encodings for the bit-serial ALU front end.
package alu_defs;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Codes 4..7 are bitwise ops; 0..3 go through the adder.
  function automatic logic is_logic_op(input logic [2:0] op);
    return op[2];
  endfunction
endpackage

// File: rtl/alu1.sv
// One-bit ALU slice (alu1) and its leaf cells: full_adder, logicunit, mux2v.
module mux2v #(
  parameter int W = 1
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module logicunit (
  input  logic       A,
  input  logic       B,
  input  logic [1:0] control,
  output logic       out
);
  always_comb begin
    out = 1'b0;
    case (control)
      2'd0: out = A & B;
      2'd1: out = A | B;
      2'd2: out = ~(A | B);
      2'd3: out = A ^ B;
      default: out = 1'b0;
    endcase
  end
endmodule

module alu1 (
  input  logic       A,
  input  logic       B,
  input  logic       carryin,
  input  logic [2:0] control,
  output logic       out,
  output logic       carryout
);
  logic b_eff, sum, lu_out;

  // control[0] selects ~B so SUB becomes A + ~B + carryin.
  mux2v #(.W(1)) u_binv (.in0(B), .in1(~B), .sel(control[0]), .out(b_eff));
  full_adder u_fa (.a(A), .b(b_eff), .cin(carryin), .sum(sum), .cout(carryout));
  logicunit u_lu (.A(A), .B(B), .control(control[1:0]), .out(lu_out));
  mux2v #(.W(1)) u_osel (.in0(sum), .in1(lu_out), .sel(control[2]), .out(out));
endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: streams operands LSB-first through one alu1 slice.
// Optional flag logic (overflow, zero) is built when SERIAL_ALU_FLAGS_EN is defined.
module serial_alu_sequencer
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);
  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, last, slice_out, slice_cout;

  assign accept = in_valid && in_ready;
  assign last   = (state_q == S_SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

  alu1 u_alu1 (
    .A        (a_sh_q[0]),
    .B        (b_sh_q[0]),
    .carryin  (carry_q),
    .control  (op_q),
    .out      (slice_out),
    .carryout (slice_cout)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SHIFT;
      S_SHIFT: if (last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Result fills from the MSB end so after WIDTH shifts bit 0 sits in place.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    op_d    = op_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (accept) begin
      a_sh_d  = A;
      b_sh_d  = B;
      op_d    = control;
      carry_d = control[0];
      cnt_d   = '0;
    end else if (state_q == S_SHIFT) begin
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      res_d   = {slice_out, res_q[WIDTH-1:1]};
      carry_d = slice_cout;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last) cout_d = is_logic_op(op_q) ? 1'b0 : slice_cout;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out      = res_q;
  assign carryout = cout_q;

`ifdef SERIAL_ALU_FLAGS_EN
  logic ovf_q, ovf_d, zero_q, zero_d, cin_msb;

  // Carry into the MSB slice; signed overflow is its mismatch with carry out.
  assign cin_msb = carry_q;

  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (last) begin
      ovf_d  = is_logic_op(op_q) ? 1'b0 : (cin_msb ^ slice_cout);
      zero_d = (res_d == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign overflow = ovf_q;
  assign zero     = zero_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif
endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Self-checking bench for serial_alu_sequencer at WIDTH=8 plus one WIDTH=32 instance.
module tb_serial_alu_sequencer;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, in_valid, out_ready, in_ready, out_valid, carryout, overflow, zero;
  logic [7:0] a, b, out;
  logic [2:0] ctl;

  logic        in_valid_w, out_ready_w, in_ready_w, out_valid_w, carryout_w, overflow_w, zero_w;
  logic [31:0] a_w, b_w, out_w;
  logic [2:0]  ctl_w;

  int errors = 0;
  int checks = 0;

  serial_alu_sequencer #(.WIDTH(8)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .control(ctl), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  serial_alu_sequencer #(.WIDTH(32)) u_dut32 (
    .clock(clock), .reset(reset), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .A(a_w), .B(b_w), .control(ctl_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .out(out_w), .carryout(carryout_w), .overflow(overflow_w), .zero(zero_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, carryout, result} from plain two's-complement arithmetic.
  function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    logic [8:0] s;
    logic [7:0] r;
    logic       co, ov;
    s = '0; r = '0; co = 1'b0; ov = 1'b0;
    case (c)
      3'd0, 3'd2: begin
        s  = {1'b0, x} + {1'b0, y};
        r  = s[7:0]; co = s[8];
        ov = (x[7] == y[7]) && (r[7] != x[7]);
      end
      3'd1, 3'd3: begin
        s  = {1'b0, x} + {1'b0, ~y} + 9'd1;
        r  = s[7:0]; co = s[8];
        ov = (x[7] != y[7]) && (r[7] != x[7]);
      end
      3'd4: r = x & y;
      3'd5: r = x | y;
      3'd6: r = ~(x | y);
      default: r = x ^ y;
    endcase
    return {ov, co, r};
  endfunction

  // Called at a negedge; returns at the negedge of the first SHIFT cycle.
  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    int n;
    in_valid = 1'b1; a = x; b = y; ctl = c;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); ctl = 3'($urandom);
  endtask

  task automatic collect(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    logic [9:0] e;
    int n;
    e = model8(x, y, c);
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_lat"}, n, 9);
    check({tag, "_out"}, out, e[7:0]);
    check({tag, "_cout"}, carryout, e[8]);
`ifdef SERIAL_ALU_FLAGS_EN
    check({tag, "_ovf"}, overflow, e[9]);
    check({tag, "_zero"}, zero, (e[7:0] == 8'h00));
`else
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_zero"}, zero, 0);
`endif
    check({tag, "_busy"}, in_ready, 0);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, "_rdy_back"}, in_ready, 1);
    check({tag, "_vld_drop"}, out_valid, 0);
  endtask

  task automatic run(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    issue(x, y, c);
    collect(tag, x, y, c);
    release_out(tag);
  endtask

  initial begin
    logic [9:0] e;
    logic [7:0] x, y;
    logic [2:0] c;
    int n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ctl = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b0; a_w = '0; b_w = '0; ctl_w = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_cout", carryout, 0);
    check("rst_ovf", overflow, 0);
    check("rst_zero", zero, 0);
    check("rst_in_ready32", in_ready_w, 1);
    @(negedge clock);

    run("add7f", 8'h7F, 8'h01, 3'd2);
    run("sub55", 8'h05, 8'h05, 3'd3);
    run("sub01", 8'h00, 8'h01, 3'd3);
    run("and",   8'hF0, 8'h3C, 3'd4);
    run("or",    8'hF0, 8'h3C, 3'd5);
    run("nor",   8'hF0, 8'h3C, 3'd6);
    run("xor",   8'hF0, 8'h3C, 3'd7);
    run("alias0", 8'hC8, 8'h64, 3'd0);
    run("alias1", 8'h80, 8'h01, 3'd1);

    // Backpressure, then the next op presented during the handshake cycle.
    issue(8'h5A, 8'h33, 3'd2);
    collect("bp", 8'h5A, 8'h33, 3'd2);
    e = model8(8'h5A, 8'h33, 3'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_hold_out", out, e[7:0]);
      check("bp_hold_vld", out_valid, 1);
      check("bp_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1; in_valid = 1'b1; a = 8'h11; b = 8'h22; ctl = 3'd7;
    @(negedge clock);
    out_ready = 1'b0;
    check("bp_rdy_rise", in_ready, 1);
    check("bp_vld_drop", out_valid, 0);
    issue(8'h11, 8'h22, 3'd7);
    collect("bp_next", 8'h11, 8'h22, 3'd7);
    release_out("bp_next");

    // Reset on the third SHIFT cycle aborts the operation.
    issue(8'hFF, 8'h01, 3'd2);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_out", out, 0);
    check("mid_rst_cout", carryout, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_zero", zero, 0);
    run("post_rst", 8'h01, 8'h01, 3'd2);

    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom); y = 8'($urandom); c = 3'($urandom_range(0, 7));
      issue(x, y, c);
      collect("rnd", x, y, c);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      check("rnd_held", out, model8(x, y, c) & 10'h0FF);
      release_out("rnd");
    end

    // WIDTH=32 carry ripple across the full word.
    in_valid_w = 1'b1; a_w = 32'hFFFF_FFFF; b_w = 32'h0000_0001; ctl_w = 3'd2;
    check("w32_accept_ready", in_ready_w, 1);
    @(posedge clock);
    @(negedge clock);
    in_valid_w = 1'b0; a_w = $urandom; b_w = $urandom;
    n = 1;
    while (!out_valid_w && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("w32_lat", n, 33);
    check("w32_out", out_w, 0);
    check("w32_cout", carryout_w, 1);
    check("w32_ovf", overflow_w, 0);
`ifdef SERIAL_ALU_FLAGS_EN
    check("w32_zero", zero_w, 1);
`else
    check("w32_zero", zero_w, 0);
`endif
    out_ready_w = 1'b1;
    @(negedge clock);
    out_ready_w = 1'b0;
    check("w32_rdy_back", in_ready_w, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
